// File: rtl/hd44780_pkg.sv
// Shared definitions for the HD44780-compatible receiver: opcodes, address map, AC stepping.
`timescale 1ns/1ps
package hd44780_pkg;

  localparam int unsigned AW         = 7;
  localparam int unsigned DW         = 8;
  localparam int unsigned DDRAM_SIZE = 80;
  localparam int unsigned LINE_LEN   = 40;

  localparam logic [AW-1:0] L1_BASE = 7'h00;
  localparam logic [AW-1:0] L1_END  = 7'h27;
  localparam logic [AW-1:0] L2_BASE = 7'h40;
  localparam logic [AW-1:0] L2_END  = 7'h67;

  localparam logic [DW-1:0] SPACE = 8'h20;

  // Instruction masks/patterns, listed in decode priority order
  localparam logic [DW-1:0] OP_DDRAM_M = 8'h80, OP_DDRAM_P = 8'h80;
  localparam logic [DW-1:0] OP_CGRAM_M = 8'hC0, OP_CGRAM_P = 8'h40;
  localparam logic [DW-1:0] OP_FSET_M  = 8'hE0, OP_FSET_P  = 8'h20;
  localparam logic [DW-1:0] OP_SHIFT_M = 8'hF0, OP_SHIFT_P = 8'h10;
  localparam logic [DW-1:0] OP_DCTL_M  = 8'hF8, OP_DCTL_P  = 8'h08;
  localparam logic [DW-1:0] OP_EMODE_M = 8'hFC, OP_EMODE_P = 8'h04;
  localparam logic [DW-1:0] OP_HOME_M  = 8'hFE, OP_HOME_P  = 8'h02;
  localparam logic [DW-1:0] OP_CLR_M   = 8'hFF, OP_CLR_P   = 8'h01;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  // True when byte b matches pattern p under mask m
  function automatic logic op_is(input logic [DW-1:0] b, input logic [DW-1:0] m,
                                 input logic [DW-1:0] p);
    return (b & m) == p;
  endfunction

  // Address counter step with line wrap in both directions
  function automatic logic [AW-1:0] ac_step(input logic [AW-1:0] a, input logic inc);
    logic [AW-1:0] r;
    if (inc) begin
      if (a == L1_END)      r = L2_BASE;
      else if (a == L2_END) r = L1_BASE;
      else                  r = a + 7'd1;
    end else begin
      if (a == L1_BASE)      r = L2_END;
      else if (a == L2_BASE) r = L1_END;
      else                   r = a - 7'd1;
    end
    return r;
  endfunction

  // Address lies on line 1 or line 2 (not in the gap, not above line 2)
  function automatic logic addr_valid(input logic [AW-1:0] a);
    return (a <= L1_END) || ((a >= L2_BASE) && (a <= L2_END));
  endfunction

  // HD44780 address to physical RAM index 0..79
  function automatic logic [AW-1:0] phys_idx(input logic [AW-1:0] a);
    return (a <= L1_END) ? a : (a - L2_BASE + 7'(LINE_LEN));
  endfunction

endpackage

// File: rtl/lcd_e_sync.sv
// Two-flop synchronizer for the writer's E/RS/data bus plus falling-edge detect on E.
`timescale 1ns/1ps
module lcd_e_sync
  import hd44780_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          e_i,
  input  logic          rs_i,
  input  logic [DW-1:0] data_i,
  output logic          fire_c_o,
  output logic          rs_o,
  output logic [DW-1:0] data_o
);

  logic [1:0]    e_sync_q;
  logic [1:0]    rs_sync_q;
  logic [DW-1:0] d_meta_q;
  logic [DW-1:0] d_sync_q;
  logic          e_prev_q;

  // Synchronizer chains and the edge-detect history register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e_sync_q  <= 2'b00;
      rs_sync_q <= 2'b00;
      d_meta_q  <= '0;
      d_sync_q  <= '0;
      e_prev_q  <= 1'b0;
    end else begin
      e_sync_q  <= {e_sync_q[0], e_i};
      rs_sync_q <= {rs_sync_q[0], rs_i};
      d_meta_q  <= data_i;
      d_sync_q  <= d_meta_q;
      e_prev_q  <= e_sync_q[1];
    end
  end

  assign fire_c_o = e_prev_q & ~e_sync_q[1];
  assign rs_o     = rs_sync_q[1];
  assign data_o   = d_sync_q;

endmodule

// File: rtl/hd44780_rx.sv
// HD44780-compatible receiver: instruction decode, address counter, flags, DDRAM image with debug read port.
`timescale 1ns/1ps
module hd44780_rx
  import hd44780_pkg::*;
#(
  parameter int unsigned CLEAR_CYCLES = 80
) (
  input  logic       in_Clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic [7:0] data,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] ac,
  output logic       busy,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       cmd_stb,
  output logic       wr_stb,
  output logic       overrun,
  output logic       bad_addr
);

  localparam int unsigned CNT_W = 16;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             clr_pend_q, clr_pend_d;
  logic [AW-1:0]    ac_q, ac_d;
  logic             inc_q, inc_d;
  logic             disp_q, disp_d, cur_q, cur_d, blink_q, blink_d, two_q, two_d;
  logic             cmd_stb_q, cmd_stb_d, wr_stb_q, wr_stb_d;
  logic             ovr_q, ovr_d, bad_q, bad_d, busy_q, busy_d;
  logic [DW-1:0]    rd_data_q;

  logic             fire_c, rx_rs;
  logic [DW-1:0]    rx_byte;
  logic             we_c;
  logic [AW-1:0]    waddr_c;
  logic [DW-1:0]    wdata_c;
  logic [AW-1:0]    rd_idx_c;

  logic [DW-1:0]    mem [DDRAM_SIZE];

  lcd_e_sync u_sync (
    .clk_i    (in_Clk),
    .rst_i    (rst),
    .e_i      (lcd_e),
    .rs_i     (lcd_rs),
    .data_i   (data),
    .fire_c_o (fire_c),
    .rs_o     (rx_rs),
    .data_o   (rx_byte)
  );

  // State, counters and all registered outputs; reset lands in the sweep
  always_ff @(posedge in_Clk or posedge rst) begin
    if (rst) begin
      state_q    <= CLEAR;
      idx_q      <= '0;
      clr_pend_q <= 1'b0;
      ac_q       <= L1_BASE;
      inc_q      <= 1'b1;
      disp_q     <= 1'b0;
      cur_q      <= 1'b0;
      blink_q    <= 1'b0;
      two_q      <= 1'b0;
      cmd_stb_q  <= 1'b0;
      wr_stb_q   <= 1'b0;
      ovr_q      <= 1'b0;
      bad_q      <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      clr_pend_q <= clr_pend_d;
      ac_q       <= ac_d;
      inc_q      <= inc_d;
      disp_q     <= disp_d;
      cur_q      <= cur_d;
      blink_q    <= blink_d;
      two_q      <= two_d;
      cmd_stb_q  <= cmd_stb_d;
      wr_stb_q   <= wr_stb_d;
      ovr_q      <= ovr_d;
      bad_q      <= bad_d;
      busy_q     <= busy_d;
    end
  end

  // Sweep FSM, transaction decode and the single RAM write port
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clr_pend_d = clr_pend_q;
    ac_d       = ac_q;
    inc_d      = inc_q;
    disp_d     = disp_q;
    cur_d      = cur_q;
    blink_d    = blink_q;
    two_d      = two_q;
    cmd_stb_d  = 1'b0;
    wr_stb_d   = 1'b0;
    ovr_d      = ovr_q;
    bad_d      = bad_q;
    we_c       = 1'b0;
    waddr_c    = '0;
    wdata_c    = SPACE;

    case (state_q)
      IDLE: begin
        if (clr_pend_q) begin
          state_d    = CLEAR;
          idx_d      = '0;
          clr_pend_d = 1'b0;
        end
      end
      CLEAR: begin
        we_c    = idx_q < CNT_W'(DDRAM_SIZE);
        waddr_c = AW'(idx_q);
        if (idx_q == CNT_W'(CLEAR_CYCLES - 1)) begin
          state_d = IDLE;
          ac_d    = L1_BASE;
          inc_d   = 1'b1;
        end else begin
          idx_d = idx_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fire_c) begin
      if ((state_q == CLEAR) || clr_pend_q) begin
        ovr_d = 1'b1;
      end else if (rx_rs) begin
        we_c     = 1'b1;
        waddr_c  = phys_idx(ac_q);
        wdata_c  = rx_byte;
        wr_stb_d = 1'b1;
        ac_d     = ac_step(ac_q, inc_q);
      end else begin
        cmd_stb_d = 1'b1;
        if (op_is(rx_byte, OP_DDRAM_M, OP_DDRAM_P)) begin
          if (addr_valid(rx_byte[6:0])) begin
            ac_d = rx_byte[6:0];
          end else begin
            bad_d = 1'b1;
            ac_d  = (rx_byte[6:0] > L2_END) ? L1_BASE : L2_BASE;
          end
        end else if (op_is(rx_byte, OP_CGRAM_M, OP_CGRAM_P)) begin
          ac_d = ac_q;
        end else if (op_is(rx_byte, OP_FSET_M, OP_FSET_P)) begin
          two_d = rx_byte[3];
        end else if (op_is(rx_byte, OP_SHIFT_M, OP_SHIFT_P)) begin
          if (!rx_byte[3]) ac_d = ac_step(ac_q, rx_byte[2]);
        end else if (op_is(rx_byte, OP_DCTL_M, OP_DCTL_P)) begin
          disp_d  = rx_byte[2];
          cur_d   = rx_byte[1];
          blink_d = rx_byte[0];
        end else if (op_is(rx_byte, OP_EMODE_M, OP_EMODE_P)) begin
          inc_d = rx_byte[1];
        end else if (op_is(rx_byte, OP_HOME_M, OP_HOME_P)) begin
          ac_d = L1_BASE;
        end else if (op_is(rx_byte, OP_CLR_M, OP_CLR_P)) begin
          clr_pend_d = 1'b1;
        end
      end
    end

    busy_d = (state_d == CLEAR);
  end

  // DDRAM storage, no reset
  always_ff @(posedge in_Clk) begin
    if (we_c) mem[waddr_c] <= wdata_c;
  end

  assign rd_idx_c = phys_idx(rd_addr);

  // Write-first registered read port; unmapped addresses read as zero
  always_ff @(posedge in_Clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (!addr_valid(rd_addr)) begin
      rd_data_q <= '0;
    end else if (we_c && (waddr_c == rd_idx_c)) begin
      rd_data_q <= wdata_c;
    end else begin
      rd_data_q <= mem[rd_idx_c];
    end
  end

  assign rd_data   = rd_data_q;
  assign ac        = ac_q;
  assign busy      = busy_q;
  assign disp_on   = disp_q;
  assign cursor_on = cur_q;
  assign blink_on  = blink_q;
  assign two_line  = two_q;
  assign cmd_stb   = cmd_stb_q;
  assign wr_stb    = wr_stb_q;
  assign overrun   = ovr_q;
  assign bad_addr  = bad_q;

endmodule
